// File: rtl/id_scan_arbiter_pkg.sv
// Shared encodings and character classes for the identifier scan arbiter.
// Imported by the recognizer core and the arbiter top.
package id_scan_defs;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_REPORT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    C_START  = 2'd0,
    C_ID     = 2'd1,
    C_REJECT = 2'd2
  } core_e;

  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5a)) ||
           ((c >= 8'h61) && (c <= 8'h7a));
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_alnum(input logic [7:0] c);
    return is_alpha(c) || is_digit(c);
  endfunction

endpackage

// File: rtl/id_scan_arbiter_core.sv
// Per-character identifier recognizer: [A-Za-z][A-Za-z0-9]*.
// A bad first char (or any non-alnum step) latches REJECT until clr.
module id_match_core
  import id_scan_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       step,
  input  logic [7:0] ch,
  output logic       ok
);

  core_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = C_START;
    end else if (step) begin
      unique case (state_q)
        C_START: state_d = is_alpha(ch) ? C_ID : C_REJECT;
        C_ID:    state_d = is_alnum(ch) ? C_ID : C_REJECT;
        default: state_d = C_REJECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= C_START;
    else       state_q <= state_d;
  end

  assign ok = (state_q == C_ID);

endmodule

// File: rtl/id_scan_arbiter.sv
// Round-robin token arbiter feeding two char streams into one
// identifier recognizer; one registered result per token.
module id_scan_arbiter
  import id_scan_defs::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAX_LEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [7:0]       req0_char,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_char,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_src,
  output logic             res_is_id,
  output logic [LEN_W-1:0] res_len,
  output logic             busy
);

  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             rr_q, rr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             res_valid_q, res_valid_d;
  logic             res_src_q, res_src_d;
  logic             res_is_id_q, res_is_id_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;

  logic       sel_valid;
  logic [7:0] sel_char;
  logic       take;
  logic       alnum;
  logic       core_ok;

  assign sel_valid = grant_q ? req1_valid : req0_valid;
  assign sel_char  = grant_q ? req1_char  : req0_char;
  assign take      = (state_q == S_SCAN) && sel_valid;
  assign alnum     = is_alnum(sel_char);

  id_match_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == S_REPORT),
    .step  (take && alnum),
    .ch    (sel_char),
    .ok    (core_ok)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    res_valid_d = 1'b0;
    res_src_d   = res_src_q;
    res_is_id_d = res_is_id_q;
    res_len_d   = res_len_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d = (req0_valid && req1_valid) ? rr_q : req1_valid;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (take && alnum) begin
          // ovf remembers that the true length passed the counter
          if (len_q == LEN_SAT) ovf_d = 1'b1;
          else                  len_d = len_q + 1'b1;
        end else if (take) begin
          state_d     = S_REPORT;
          res_valid_d = 1'b1;
          res_src_d   = grant_q;
          res_len_d   = len_q;
          res_is_id_d = core_ok && (len_q != '0) && !ovf_q &&
                        (int'(len_q) <= MAX_LEN);
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
        rr_d    = ~grant_q;
        len_d   = '0;
        ovf_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      rr_q        <= 1'b0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_src_q   <= 1'b0;
      res_is_id_q <= 1'b0;
      res_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
      res_src_q   <= res_src_d;
      res_is_id_q <= res_is_id_d;
      res_len_q   <= res_len_d;
    end
  end

  assign req0_ready = (state_q == S_SCAN) && !grant_q;
  assign req1_ready = (state_q == S_SCAN) &&  grant_q;
  assign res_valid  = res_valid_q;
  assign res_src    = res_src_q;
  assign res_is_id  = res_is_id_q;
  assign res_len    = res_len_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_id_scan_arbiter.sv
// Directed bench for id_scan_arbiter: default instance plus a
// LEN_W=3 / MAX_LEN=4 instance sharing the same input streams.
module tb_id_scan_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [7:0] c0 = 8'h0, c1 = 8'h0;

  logic r0, r1, rv, rs, rid, bz;
  logic [7:0] rl;
  logic r0b, r1b, rvb, rsb, ridb, bzb;
  logic [2:0] rlb;

  always #5 clk = ~clk;

  id_scan_arbiter dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_char(c0), .req0_ready(r0),
    .req1_valid(v1), .req1_char(c1), .req1_ready(r1),
    .res_valid(rv), .res_src(rs), .res_is_id(rid),
    .res_len(rl), .busy(bz)
  );

  id_scan_arbiter #(.LEN_W(3), .MAX_LEN(4)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_char(c0), .req0_ready(r0b),
    .req1_valid(v1), .req1_char(c1), .req1_ready(r1b),
    .res_valid(rvb), .res_src(rsb), .res_is_id(ridb),
    .res_len(rlb), .busy(bzb)
  );

  typedef struct {
    bit src;
    bit id_a;
    int len_a;
    bit id_b;
    int len_b;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  bit   obs_src[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   stall0 = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic bit tb_alpha(input logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  function automatic bit tb_alnum(input logic [7:0] c);
    return tb_alpha(c) || (c >= "0" && c <= "9");
  endfunction

  // Reference: n alnum chars, fa = first char was a letter.
  task automatic push_res(input bit src, input bit fa, input int n,
                          input int acc);
    exp_t e;
    e.src   = src;
    e.len_a = (n > 255) ? 255 : n;
    e.id_a  = fa && n >= 1 && n <= 32 && n <= 255;
    e.len_b = (n > 7) ? 7 : n;
    e.id_b  = fa && n >= 1 && n <= 4 && n <= 7;
    e.cyc   = acc + 1;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk("one_ready", {31'd0, r0 & r1}, 0);
    chk("ready_idle_rep", {31'd0, (r0 | r1) & (!bz | rv)}, 0);
    chk("b_ready", {30'd0, r1b, r0b}, {30'd0, r1, r0});
    chk("b_valid", {31'd0, rvb}, {31'd0, rv});
    if (rv) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_res", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        obs_src.push_back(rs);
        chk("res_src", {31'd0, rs}, {31'd0, e.src});
        chk("res_is_id", {31'd0, rid}, {31'd0, e.id_a});
        chk("res_len", {24'd0, rl}, e.len_a);
        chk("res_lat", cyc, e.cyc);
        chk("b_src", {31'd0, rsb}, {31'd0, e.src});
        chk("b_is_id", {31'd0, ridb}, {31'd0, e.id_b});
        chk("b_len", {29'd0, rlb}, e.len_b);
      end
    end
  end

  task automatic drv0(input string s);
    int n = 0;
    bit fa = 0;
    stall0 = 0;
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] ch;
      int w = 0;
      int acc;
      ch = s[i];
      v0 = 1'b1;
      c0 = ch;
      @(negedge clk);
      while (!r0 && w < 400) begin
        @(negedge clk);
        w++;
      end
      stall0 += w;
      if (w >= 400) begin
        chk("drv0_timeout", 1, 0);
        break;
      end
      acc = cyc;
      @(posedge clk);
      #1;
      if (tb_alnum(ch)) begin
        n++;
        if (n == 1) fa = tb_alpha(ch);
      end else begin
        push_res(1'b0, fa, n, acc);
        n = 0;
        fa = 0;
      end
    end
    v0 = 1'b0;
  endtask

  task automatic drv1(input string s);
    int n = 0;
    bit fa = 0;
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] ch;
      int w = 0;
      int acc;
      ch = s[i];
      v1 = 1'b1;
      c1 = ch;
      @(negedge clk);
      while (!r1 && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (w >= 400) begin
        chk("drv1_timeout", 1, 0);
        break;
      end
      acc = cyc;
      @(posedge clk);
      #1;
      if (tb_alnum(ch)) begin
        n++;
        if (n == 1) fa = tb_alpha(ch);
      end else begin
        push_res(1'b1, fa, n, acc);
        n = 0;
        fa = 0;
      end
    end
    v1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", {31'd0, rv}, 0);
    chk("rst_src", {31'd0, rs}, 0);
    chk("rst_is_id", {31'd0, rid}, 0);
    chk("rst_len", {24'd0, rl}, 0);
    chk("rst_busy", {31'd0, bz}, 0);
    chk("rst_ready", {30'd0, r1, r0}, 0);
    chk("rst_b_len", {29'd0, rlb}, 0);
    chk("rst_b_busy", {31'd0, bzb}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_seq(input string tag, input logic [3:0] exp,
                         input int n);
    logic [3:0] got = 4'd0;
    chk({tag, "_cnt"}, obs_src.size(), n);
    for (int i = 0; i < obs_src.size() && i < 4; i++) got[i] = obs_src[i];
    chk(tag, {28'd0, got}, {28'd0, exp});
    obs_src.delete();
  endtask

  initial begin
    string s;
    do_reset();

    drv0("abc1/");
    chk("t1_stalls", stall0, 1);
    repeat (2) @(negedge clk);
    chk("t1_busy", {31'd0, bz}, 0);
    repeat (3) @(negedge clk);
    chk("t1_hold_valid", {31'd0, rv}, 0);
    chk("t1_hold_len", {24'd0, rl}, 4);
    chk("t1_hold_id", {31'd0, rid}, 1);
    chk_seq("t1_seq", 4'b0000, 1);

    do_reset();
    fork
      drv0("x1 ");
      drv1("9z ");
    join
    repeat (3) @(negedge clk);
    chk_seq("t2_seq", 4'b0010, 2);

    do_reset();
    fork
      drv0("a1.bb.");
      drv1("c.d2.");
    join
    repeat (3) @(negedge clk);
    chk_seq("t3_seq", 4'b1010, 4);

    do_reset();
    drv1("/");
    drv0("q;");
    repeat (3) @(negedge clk);
    chk_seq("t4_seq", 4'b0001, 2);

    drv0("abcde.");
    drv0("aaaaaaaaa.");
    s = "";
    for (int i = 0; i < 32; i++) s = {s, "a"};
    drv0({s, "."});
    drv0({s, "b."});
    s = "";
    for (int i = 0; i < 300; i++) s = {s, "a"};
    drv0({s, "."});
    repeat (3) @(negedge clk);
    chk_seq("t5_cnt", 4'b0000, 5);

    drv0("ab");
    #2;
    do_reset();
    chk("t6_busy", {31'd0, bz}, 0);
    fork
      drv0("ok.");
      drv1("z.");
    join
    repeat (3) @(negedge clk);
    chk_seq("t6_seq", 4'b0010, 2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
